// File: rtl/arbitro_mux_memoria.sv
// Round-robin arbiter feeding a 2:1 registered mux with a one-word output register.
// Two valid/ready lanes share data_out; grants rotate with a bounded burst length.
module arbitro_mux_memoria #(
  parameter  int WIDTH     = 2,
  parameter  int MAX_BURST = 4,
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in0,
  input  logic [WIDTH-1:0] data_in0,
  output logic             ready_in0,
  input  logic             valid_in1,
  input  logic [WIDTH-1:0] data_in1,
  output logic             ready_in1,
  input  logic             ready_out,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out,
  output logic             selector,
  output logic             busy,
  output logic [1:0]       dbg_state_o,
  output logic [CNT_W-1:0] dbg_burst_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic               valid_out_q, valid_out_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;

  // Valid/ready: a lane word moves on an edge exactly when its valid and ready are both
  // high; data_out moves to the consumer when valid_out and ready_out are both high.
  logic               can_load;
  logic               gnt_lane;
  logic               gnt_valid;
  logic               other_valid;
  logic [WIDTH-1:0]   gnt_data;
  logic               accept;
  state_e             other_gnt;

  assign can_load    = !valid_out_q || ready_out;
  assign gnt_lane    = (state_q == GNT1);
  assign gnt_valid   = gnt_lane ? valid_in1 : valid_in0;
  assign other_valid = gnt_lane ? valid_in0 : valid_in1;
  assign gnt_data    = gnt_lane ? data_in1 : data_in0;
  assign other_gnt   = gnt_lane ? GNT0 : GNT1;
  assign accept      = (state_q != IDLE) && gnt_valid && can_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      burst_cnt_q <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      IDLE: begin
        // On a tie the lane that was not served last wins.
        if (valid_in0 && valid_in1) state_d = last_q ? GNT0 : GNT1;
        else if (valid_in0)         state_d = GNT0;
        else if (valid_in1)         state_d = GNT1;
      end
      GNT0, GNT1: begin
        if (accept) begin
          if (burst_cnt_q == LAST_CNT) begin
            burst_cnt_d = '0;
            if (other_valid) begin
              state_d = other_gnt;
              last_d  = gnt_lane;
            end
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end else if (!gnt_valid) begin
          last_d      = gnt_lane;
          burst_cnt_d = '0;
          state_d     = other_valid ? other_gnt : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_in0       = (state_q == GNT0) && can_load;
    ready_in1       = (state_q == GNT1) && can_load;
    selector        = gnt_lane;
    busy            = (state_q != IDLE) || valid_out_q;
    valid_out       = valid_out_q;
    data_out        = data_out_q;
    dbg_state_o     = state_q;
    dbg_burst_cnt_o = burst_cnt_q;
    // A load in the same cycle as a pop keeps valid_out high for full throughput.
    valid_out_d     = accept ? 1'b1 : (ready_out ? 1'b0 : valid_out_q);
    data_out_d      = accept ? gnt_data : data_out_q;
  end

endmodule

// File: tb/tb_arbitro_mux_memoria.sv
// Bench for arbitro_mux_memoria: hand-derived vector table, directed corner sequences,
// and randomized traffic against a cycle-level behavioural model with a word scoreboard.
module tb_arbitro_mux_memoria;
  localparam int WIDTH     = 2;
  localparam int MAX_BURST = 4;
  localparam int CNT_W     = $clog2(MAX_BURST + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_in0, valid_in1, ready_out;
  logic [WIDTH-1:0] data_in0, data_in1;
  logic             ready_in0, ready_in1, valid_out, selector, busy;
  logic [WIDTH-1:0] data_out;
  logic [1:0]       dbg_state;
  logic [CNT_W-1:0] dbg_burst_cnt;

  arbitro_mux_memoria #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .valid_in0(valid_in0), .data_in0(data_in0), .ready_in0(ready_in0),
    .valid_in1(valid_in1), .data_in1(data_in1), .ready_in1(ready_in1),
    .ready_out(ready_out), .valid_out(valid_out), .data_out(data_out),
    .selector(selector), .busy(busy),
    .dbg_state_o(dbg_state), .dbg_burst_cnt_o(dbg_burst_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: grant is -1 (nobody), 0 or 1.
  int         m_gnt, m_last, m_cnt;
  bit         m_vo;
  int         m_do;
  int         wait_cnt[2];
  bit         last_acc[2];
  logic [WIDTH-1:0] exp_q[$];

  bit in_rst, in_v0, in_v1, in_rdy;
  int in_d0, in_d1;

  typedef struct {
    bit rst; bit v0; int d0; bit v1; int d1; bit rdy;
    bit chk; bit e_vo; int e_do; bit e_sel; bit e_r0; bit e_r1; bit e_busy;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit lane_v(input int k);
    return (k == 0) ? in_v0 : in_v1;
  endfunction

  function automatic int lane_d(input int k);
    return (k == 0) ? in_d0 : in_d1;
  endfunction

  task automatic apply(input bit rst, input bit v0, input int d0, input bit v1, input int d1,
                       input bit rdy);
    in_rst = rst; in_v0 = v0; in_d0 = d0; in_v1 = v1; in_d1 = d1; in_rdy = rdy;
    reset = rst; valid_in0 = v0; data_in0 = WIDTH'(d0);
    valid_in1 = v1; data_in1 = WIDTH'(d1); ready_out = rdy;
  endtask

  task automatic compare_model();
    bit can;
    can = !m_vo || in_rdy;
    chk("ready_in0", 32'(ready_in0), 32'(m_gnt == 0 && can));
    chk("ready_in1", 32'(ready_in1), 32'(m_gnt == 1 && can));
    chk("selector",  32'(selector),  32'(m_gnt == 1));
    chk("valid_out", 32'(valid_out), 32'(m_vo));
    chk("data_out",  32'(data_out),  32'(m_do));
    chk("busy",      32'(busy),      32'(m_gnt != -1 || m_vo));
    chk("burst_cnt", 32'(dbg_burst_cnt), 32'(m_cnt));
    if (valid_out && ready_out && !in_rst) begin
      if (exp_q.size() == 0) chk("sb_empty_pop", 32'(1), 32'(0));
      else chk("sb_word", 32'(data_out), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic tick();
    bit can;
    int acc, k, o;
    can = !m_vo || in_rdy;
    acc = -1;
    if (!in_rst && m_gnt >= 0 && lane_v(m_gnt) && can) acc = m_gnt;
    @(posedge clk);
    #1;
    last_acc[0] = (acc == 0);
    last_acc[1] = (acc == 1);
    if (in_rst) begin
      m_gnt = -1; m_last = 1; m_cnt = 0; m_vo = 0; m_do = 0;
      exp_q.delete();
      wait_cnt[0] = 0; wait_cnt[1] = 0;
      return;
    end
    if (acc >= 0) begin
      exp_q.push_back(WIDTH'(lane_d(acc)));
      chk("starve_bound", 32'(wait_cnt[acc] <= MAX_BURST + 1), 32'(1));
      wait_cnt[acc] = 0;
      if (lane_v(1 - acc)) wait_cnt[1 - acc]++;
    end
    for (int i = 0; i < 2; i++) if (!lane_v(i)) wait_cnt[i] = 0;
    if (m_gnt == -1) begin
      if (in_v0 && in_v1) m_gnt = (m_last == 1) ? 0 : 1;
      else if (in_v0)     m_gnt = 0;
      else if (in_v1)     m_gnt = 1;
    end else begin
      k = m_gnt; o = 1 - k;
      if (acc >= 0) begin
        if (m_cnt + 1 == MAX_BURST) begin
          m_cnt = 0;
          if (lane_v(o)) begin m_gnt = o; m_last = k; end
        end else m_cnt++;
      end else if (!lane_v(k)) begin
        m_last = k; m_cnt = 0;
        m_gnt = lane_v(o) ? o : -1;
      end
    end
    if (acc >= 0) begin m_do = lane_d(acc); m_vo = 1; end
    else if (in_rdy) m_vo = 0;
  endtask

  task automatic step(input bit rst, input bit v0, input int d0, input bit v1, input int d1,
                      input bit rdy);
    apply(rst, v0, d0, v1, d1, rdy);
    #2;
    compare_model();
    tick();
  endtask

  task automatic add(input bit rst, input bit v0, input int d0, input bit v1, input int d1,
                     input bit rdy, input bit c, input bit vo, input int dout, input bit sel,
                     input bit r0, input bit r1, input bit b);
    vec_t v;
    v = '{rst, v0, d0, v1, d1, rdy, c, vo, dout, sel, r0, r1, b};
    tbl.push_back(v);
  endtask

  initial begin
    bit rv[2];
    int rd[2];
    m_gnt = -1; m_last = 1; m_cnt = 0; m_vo = 0; m_do = 0;
    wait_cnt[0] = 0; wait_cnt[1] = 0;

    // Reset, single lane, then contention with MAX_BURST=4 rotation.
    add(1, 0,0, 0,0, 0,  0, 0,0,0,0,0,0);
    add(1, 0,0, 0,0, 0,  1, 0,0,0,0,0,0);
    add(0, 0,0, 0,0, 0,  1, 0,0,0,0,0,0);
    add(0, 1,2, 0,0, 1,  1, 0,0,0,0,0,0);
    add(0, 1,2, 0,0, 1,  1, 0,0,0,1,0,1);
    add(0, 0,2, 0,0, 1,  1, 1,2,0,1,0,1);
    add(0, 0,0, 0,0, 1,  1, 0,2,0,0,0,0);
    add(1, 0,0, 0,0, 1,  1, 0,2,0,0,0,0);
    add(0, 1,1, 1,3, 1,  1, 0,0,0,0,0,0);
    add(0, 1,1, 1,3, 1,  1, 0,0,0,1,0,1);
    for (int i = 0; i < 3; i++) add(0, 1,1, 1,3, 1,  1, 1,1,0,1,0,1);
    add(0, 1,1, 1,3, 1,  1, 1,1,1,0,1,1);
    for (int i = 0; i < 3; i++) add(0, 1,1, 1,3, 1,  1, 1,3,1,0,1,1);
    add(0, 1,1, 1,3, 1,  1, 1,3,0,1,0,1);

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].rdy);
      #2;
      if (tbl[i].chk) begin
        chk($sformatf("vec%0d", i),
            {26'(0), valid_out, 1'(0), data_out, selector, ready_in0, ready_in1, busy},
            {26'(0), tbl[i].e_vo, 1'(0), WIDTH'(tbl[i].e_do), tbl[i].e_sel, tbl[i].e_r0,
             tbl[i].e_r1, tbl[i].e_busy});
        compare_model();
      end
      tick();
    end

    // Backpressure mid-burst: everything frozen for 3 cycles, then resumes.
    step(1, 0,0, 0,0, 0); step(1, 0,0, 0,0, 0);
    step(0, 1,1, 0,0, 1); step(0, 1,1, 0,0, 1); step(0, 1,2, 0,0, 1);
    for (int i = 0; i < 3; i++) begin
      apply(0, 1,3, 0,0, 0);
      #2;
      chk("bp_ready_in0", 32'(ready_in0), 32'(0));
      chk("bp_burst_cnt", 32'(dbg_burst_cnt), 32'(2));
      chk("bp_hold", {30'(0), valid_out, data_out[0]}, 32'(2));
      chk("bp_data", 32'(data_out), 32'(2));
      compare_model();
      tick();
    end
    step(0, 1,3, 0,0, 1); step(0, 0,0, 0,0, 1); step(0, 0,0, 0,0, 1);

    // Lane drop hands over to the waiting lane, then the tie follows last.
    step(1, 0,0, 0,0, 0); step(1, 0,0, 0,0, 0);
    step(0, 1,1, 1,2, 1); step(0, 1,1, 1,2, 1); step(0, 1,3, 1,2, 1);
    step(0, 0,0, 1,2, 1);
    apply(0, 0,0, 1,2, 1); #2;
    chk("drop_sel", 32'(selector), 32'(1));
    chk("drop_ready_in1", 32'(ready_in1), 32'(1));
    compare_model(); tick();
    step(0, 0,0, 0,0, 1);
    step(0, 1,1, 1,2, 1);
    apply(0, 1,1, 1,2, 1); #2;
    chk("tie_last1_sel", 32'(selector), 32'(0));
    chk("tie_last1_r0", 32'(ready_in0), 32'(1));
    compare_model(); tick();
    step(0, 0,0, 0,0, 1);
    step(0, 1,1, 1,2, 1);
    apply(0, 1,1, 1,2, 1); #2;
    chk("tie_last0_sel", 32'(selector), 32'(1));
    chk("tie_last0_r1", 32'(ready_in1), 32'(1));
    compare_model(); tick();

    // Reset while a word is held under GNT1.
    step(1, 0,0, 0,0, 0); step(1, 0,0, 0,0, 0);
    step(0, 0,0, 1,3, 1); step(0, 0,0, 1,3, 1);
    apply(1, 0,0, 1,3, 0); #2;
    chk("rst_mid_pre", {30'(0), selector, valid_out}, 32'(3));
    compare_model(); tick();
    apply(0, 0,0, 0,0, 1); #2;
    chk("rst_mid_post", {29'(0), valid_out, selector, busy}, 32'(0));
    chk("rst_mid_cnt", 32'(dbg_burst_cnt), 32'(0));
    compare_model(); tick();

    // Randomized traffic.
    rv[0] = 0; rv[1] = 0; rd[0] = 0; rd[1] = 0;
    last_acc[0] = 0; last_acc[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (rv[k]) begin
          if (last_acc[k]) begin
            rv[k] = ($urandom_range(0, 3) != 0);
            rd[k] = $urandom_range(0, 3);
          end else if ($urandom_range(0, 15) == 0) rv[k] = 0;
        end else if ($urandom_range(0, 1) == 1) begin
          rv[k] = 1;
          rd[k] = $urandom_range(0, 3);
        end
      end
      step($urandom_range(0, 199) == 0, rv[0], rd[0], rv[1], rd[1],
           $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
